// File: rtl/alu_sequencer.sv
// Multi-cycle control sequencer for the accumulator ALU: fetches 9-bit instructions,
// drives ALU/datapath controls, keeps carry/zero/parity flags and resolves branches.
module alu_sequencer #(
  parameter int PC_W  = 10,
  parameter int LUT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             done,
  output logic [PC_W-1:0]  instr_addr,
  input  logic [8:0]       instr_data,
  output logic [LUT_W-1:0] lut_idx,
  input  logic [PC_W-1:0]  lut_target,
  output logic [3:0]       alu_cmd,
  output logic             alu_ldImmed,
  output logic             alu_cin,
  input  logic             alu_cout,
  input  logic             alu_zero,
  input  logic             alu_pari,
  output logic [7:0]       imm,
  output logic             opr_sel,
  output logic [3:0]       reg_addr,
  output logic             acc_we,
  output logic             reg_we,
  output logic             dmem_re,
  output logic             dmem_we,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_p
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEMWAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] OP_SHIFT = 4'b0000;
  localparam logic [3:0] OP_BRA   = 4'b0001;
  localparam logic [3:0] OP_BZ    = 4'b0010;
  localparam logic [3:0] OP_BC    = 4'b0011;
  localparam logic [3:0] OP_LOAD  = 4'b0100;
  localparam logic [3:0] OP_STORE = 4'b0101;
  localparam logic [3:0] OP_PUSH  = 4'b0110;
  localparam logic [3:0] OP_POP   = 4'b0111;
  localparam logic [3:0] OP_AND   = 4'b1000;
  localparam logic [3:0] OP_OR    = 4'b1001;
  localparam logic [3:0] OP_XOR   = 4'b1010;
  localparam logic [3:0] OP_NOT   = 4'b1011;
  localparam logic [3:0] OP_ADD   = 4'b1100;
  localparam logic [3:0] OP_SUB   = 4'b1101;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt, pc_inc;
  logic            start_q;
  logic            c_we;
  logic            flags_clr;
  logic [3:0]      opcode;

  assign instr_addr = pc;
  assign pc_inc     = pc + 1'b1;
  assign opcode     = instr_data[7:4];

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    done        = (state == S_DONE);
    alu_cmd     = '0;
    alu_ldImmed = 1'b0;
    alu_cin     = 1'b0;
    imm         = '0;
    opr_sel     = 1'b0;
    reg_addr    = '0;
    lut_idx     = '0;
    acc_we      = 1'b0;
    reg_we      = 1'b0;
    dmem_re     = 1'b0;
    dmem_we     = 1'b0;
    c_we        = 1'b0;
    flags_clr   = 1'b0;

    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_EXEC;
      S_EXEC: begin
        state_nxt = S_FETCH;
        pc_nxt    = pc_inc;
        if (instr_data[8]) begin
          alu_ldImmed = 1'b1;
          imm         = instr_data[7:0];
          acc_we      = 1'b1;
        end else begin
          alu_cmd  = opcode;
          reg_addr = instr_data[3:0];
          lut_idx  = instr_data[LUT_W-1:0];
          imm      = {4'b0000, instr_data[3:0]};
          case (opcode)
            OP_SHIFT: begin
              acc_we = 1'b1;
              c_we   = 1'b1;
            end
            OP_AND, OP_OR, OP_XOR, OP_NOT, OP_POP: acc_we = 1'b1;
            OP_ADD, OP_SUB: begin
              acc_we  = 1'b1;
              c_we    = 1'b1;
              alu_cin = flag_c;
            end
            OP_PUSH:  reg_we  = 1'b1;
            OP_STORE: dmem_we = 1'b1;
            OP_LOAD: begin
              dmem_re   = 1'b1;
              state_nxt = S_MEMWAIT;
              pc_nxt    = pc;
            end
            OP_BRA: pc_nxt = lut_target;
            OP_BZ:  if (flag_z) pc_nxt = lut_target;
            OP_BC:  if (flag_c) pc_nxt = lut_target;
            OP_HALT: begin
              state_nxt = S_DONE;
              pc_nxt    = pc;
            end
            default: ;
          endcase
        end
      end
      S_MEMWAIT: begin
        alu_cmd   = OP_LOAD;
        opr_sel   = 1'b1;
        acc_we    = 1'b1;
        pc_nxt    = pc_inc;
        state_nxt = S_FETCH;
      end
      S_DONE: begin
        if (start && !start_q) begin
          state_nxt = S_FETCH;
          pc_nxt    = '0;
          flags_clr = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Reset is synchronous, so suppress write strobes in the reset cycle to abort cleanly.
    if (reset) begin
      acc_we  = 1'b0;
      reg_we  = 1'b0;
      dmem_re = 1'b0;
      dmem_we = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      pc      <= '0;
      start_q <= 1'b0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
      flag_p  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      start_q <= start;
      if (flags_clr) begin
        flag_c <= 1'b0;
        flag_z <= 1'b0;
        flag_p <= 1'b0;
      end else begin
        if (c_we) flag_c <= alu_cout;
        if (acc_we) begin
          flag_z <= alu_zero;
          flag_p <= alu_pari;
        end
      end
    end
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle control sequencer that fetches 9-bit instructions and drives the accumulator ALU's command, carry-in and immediate-load inputs. It is the initiator side of the ALU interface: it consumes the ALU status outputs (cout, zero, pari), keeps them in flag registers, and resolves branches.
It also drives accumulator, register-file and data-memory enables. It sits between instruction memory and the datapath, and starts and stops under a start/done handshake from the testbench or top level.

Parameters:
PC_W, 10, program counter / instruction address width
LUT_W, 4, branch-target lookup index width (taken from instr[3:0])

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  run request from top level
done  out  1  program halted
instr_addr  out  PC_W  instruction memory address (= pc)
instr_data  in  9  instruction word, valid one cycle after instr_addr
lut_idx  out  LUT_W  branch target table index
lut_target  in  PC_W  branch target address (combinational table)
alu_cmd  out  4  ALU operation select
alu_ldImmed  out  1  ALU immediate-load select
alu_cin  out  1  ALU carry-in
alu_cout  in  1  ALU carry-out
alu_zero  in  1  ALU zero flag
alu_pari  in  1  ALU parity flag
imm  out  8  zero-extended immediate / shift field to operand mux
opr_sel  out  1  operand mux: 0 = register file, 1 = data memory
reg_addr  out  4  register file index (instr[3:0])
acc_we  out  1  accumulator write enable
reg_we  out  1  register file write enable
dmem_re  out  1  data memory read enable
dmem_we  out  1  data memory write enable
flag_c, flag_z, flag_p  out  1 each  registered carry / zero / parity flags

Behaviour:
- Reset: state=IDLE; pc=0; flags=0. done, all enables, alu_ldImmed, alu_cin, opr_sel are 0; alu_cmd=0; imm=0. Reset mid-operation aborts the instruction with no write issued.
- Decode: instr[8]=1 gives alu_ldImmed=1 and imm=instr[7:0]. instr[8]=0 gives alu_cmd=instr[7:4], reg_addr=instr[3:0], lut_idx=instr[3:0], imm={4'b0,instr[3:0]}.
- States:
  - IDLE: outputs idle. start=1 → FETCH.
  - FETCH: instr_addr=pc, no enables. Always → EXEC.
  - EXEC: drives decode outputs and enables for one cycle.
  - MEMWAIT: load only.
  - DONE.
- EXEC enables:
  - Load immediate, shift 0000, logic 1000–1011, add/sub 1100/1101, pop 0111: acc_we=1.
  - Push 0110: reg_we=1.
  - Store 0101: dmem_we=1.
  - Load 0100: dmem_re=1, → MEMWAIT.
  - Branches 0001–0011 and 1110: no writes.
  - Halt 1111: → DONE.
  - All other cases → FETCH.
- MEMWAIT: alu_cmd=0100, opr_sel=1, acc_we=1. Then pc+1 → FETCH.
- Latency: 2 cycles per instruction; load takes 3.
- Carry: alu_cin=flag_c only for 1100/1101, else 0. flag_c <= alu_cout at EXEC of 0000, 1100 and 1101.
- Zero/parity: flag_z/flag_p <= alu_zero/alu_pari on every cycle where acc_we=1, including MEMWAIT.
- Flags are otherwise held, and all flag updates are registered on that cycle's edge.
- Branch 0001 is unconditional; 0010 is taken if flag_z=1; 0011 is taken if flag_c=1. Taken: pc <= lut_target. Not taken: pc <= pc+1.
- pc arithmetic is modulo 2^PC_W: pc=2^PC_W−1 increments to 0.
- DONE: done=1 held, pc and flags held, no enables. A start rising edge (start=1 with previous start=0) resets pc=0 and flags=0, clears done, → FETCH. start held high in DONE does not restart.
- start is ignored in FETCH/EXEC/MEMWAIT.

Test Plan:
- Reset held 2 cycles, then start=1 → first FETCH instr_addr=0. Program 9'h1_05 (ldi 5), 9'h0F0 (halt) → acc_we pulses once with alu_ldImmed=1 and imm=8'h05; done=1 on cycle 5 after start.
- Add with carry: flag_c=1 from a prior shift with alu_cout=1, then 9'h0C3 → alu_cmd=1100, alu_cin=1, reg_addr=3; flag_c updated from alu_cout.
- Branch: flag_z=1, instr 9'h022 with lut_target=0x3A0 → next instr_addr=0x3A0. Same with flag_z=0 → pc+1.
- Load at pc=7: 9'h041 → EXEC dmem_re=1; MEMWAIT acc_we=1, opr_sel=1; next FETCH instr_addr=8 three cycles after the previous FETCH.
- Wrap: pc=0x3FF executes a non-branch → next instr_addr=0x000.
- Assert reset during MEMWAIT → next cycle IDLE, acc_we=0, pc=0, flags=0. After halt, start held high keeps done=1; toggling start low then high restarts at pc=0.
